// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: IF/ID-side hazard bus between the pipeline and the
// load-use hazard unit.
//   master : pipeline side, drives the IF/ID instruction fields plus
//            freeze/flush, and receives the stall controls and stall counter.
//   slave  : hazard unit side, the mirror of master.
// Signals:
//   id_mem_read / id_mem_write : IF/ID instruction is a load / a store
//   id_rd, id_rs, id_rt        : register specifiers of the IF/ID instruction
//   id_rs_used, id_rt_used     : the source operand is actually read
//   freeze, flush              : whole-pipeline hold / IF/ID+ID/EX squash
//   stall_pc, stall_if_id      : hold PC / hold IF/ID
//   set_ctrl_zero              : insert a bubble into ID/EX
//   stall_cnt                  : saturating stall-cycle counter
interface hazard_scoreboard_if #(
  parameter int REG_W  = 4,
  parameter int PERF_W = 16
);
  logic              id_mem_read;
  logic              id_mem_write;
  logic [REG_W-1:0]  id_rd;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              freeze;
  logic              flush;
  logic              stall_pc;
  logic              stall_if_id;
  logic              set_ctrl_zero;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output id_mem_read, id_mem_write, id_rd, id_rs, id_rt,
           id_rs_used, id_rt_used, freeze, flush,
    input  stall_pc, stall_if_id, set_ctrl_zero, stall_cnt
  );

  modport slave (
    input  id_mem_read, id_mem_write, id_rd, id_rs, id_rt,
           id_rs_used, id_rt_used, freeze, flush,
    output stall_pc, stall_if_id, set_ctrl_zero, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use hazard unit sitting beside the ID stage.
// A per-register countdown tracks loads in flight; a consumer of a pending
// register is held in IF/ID (PC and IF/ID held, ID/EX bubbled) until the
// loaded value can be forwarded.
// Ports:
//   clk   : core clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : hazard_scoreboard_if.slave (instruction fields in, stall controls
//           and saturating stall counter out)
module hazard_scoreboard #(
  parameter int REG_W           = 4,
  parameter int NUM_REGS        = 16,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int ZERO_REG_EXEMPT = 1,
  parameter int MM_FWD_EN       = 1,
  parameter int PERF_W          = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  bus
);

  localparam int CW = $clog2(LOAD_USE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_USE_CYCLES);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0]     cnt      [NUM_REGS];
  logic [CW-1:0]     cnt_nxt  [NUM_REGS];
  logic [NUM_REGS-1:0] young;
  logic [NUM_REGS-1:0] young_nxt;
  logic [PERF_W-1:0] perf;

  logic [CW-1:0] cnt_rs;
  logic [CW-1:0] cnt_rt;
  logic          hit_rs;
  logic          hit_rt;
  logic          mm;
  logic          stall;
  logic          rd_exempt;
  logic          issue;

  // Hazard detection: purely combinational from state and current inputs.
  always_comb begin
    cnt_rs = cnt[bus.id_rs];
    cnt_rt = cnt[bus.id_rt];
    hit_rs = bus.id_rs_used && (cnt_rs != '0);
    hit_rt = bus.id_rt_used && (cnt_rt != '0);
    // A store whose only pending operand is its data (rt), one cycle from
    // ready, can take the value via mem-to-mem forwarding instead of stalling.
    mm = (MM_FWD_EN != 0) && bus.id_mem_write && hit_rt && !hit_rs &&
         (cnt_rt == ONE) && (bus.id_rs != bus.id_rt);
    stall = !bus.freeze && !bus.flush && (hit_rs || hit_rt) && !mm;
    rd_exempt = (ZERO_REG_EXEMPT != 0) && (bus.id_rd == '0);
    issue = bus.id_mem_read && !stall && !bus.freeze && !bus.flush && !rd_exempt;
  end

  assign bus.stall_pc      = stall;
  assign bus.stall_if_id   = stall;
  assign bus.set_ctrl_zero = stall;
  assign bus.stall_cnt     = perf;

  // Scoreboard next state. Freeze holds everything; flush squashes the load
  // issued at the previous advancing edge (young) while older loads keep
  // counting down. A new issue overrides the decrement of its own entry,
  // which is what reloads a back-to-back load to the same rd.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r] = cnt[r];
    end
    young_nxt = young;
    if (!bus.freeze) begin
      young_nxt = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (bus.flush && young[r]) begin
          cnt_nxt[r] = '0;
        end else if (cnt[r] != '0) begin
          cnt_nxt[r] = cnt[r] - ONE;
        end
      end
      if (issue) begin
        cnt_nxt[bus.id_rd]   = LOAD_VAL;
        young_nxt[bus.id_rd] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
      young <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      young <= young_nxt;
    end
  end

  // Stall-cycle performance counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf <= '0;
    end else if (stall && (perf != '1)) begin
      perf <= perf + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed bench for hazard_scoreboard.
// Four instances cover the parameter sets of interest:
//   A default, B LOAD_USE_CYCLES=2, C MM_FWD_EN=0, D PERF_W=2.
// Expected values are pushed to a queue as each step is driven and popped
// when the DUT output is sampled, 2 ns after the drive point (3 ns past the
// rising edge).
module tb_hazard_scoreboard;

  logic clk;
  logic rst_n;

  hazard_scoreboard_if #(.REG_W(4), .PERF_W(16)) a_if ();
  hazard_scoreboard_if #(.REG_W(4), .PERF_W(16)) b_if ();
  hazard_scoreboard_if #(.REG_W(4), .PERF_W(16)) c_if ();
  hazard_scoreboard_if #(.REG_W(4), .PERF_W(2))  d_if ();

  hazard_scoreboard dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  hazard_scoreboard #(.LOAD_USE_CYCLES(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  hazard_scoreboard #(.MM_FWD_EN(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));
  hazard_scoreboard #(.PERF_W(2)) dut_d (.clk(clk), .rst_n(rst_n), .bus(d_if));

  localparam int DA = 0;
  localparam int DB = 1;
  localparam int DC = 2;
  localparam int DD = 3;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int d, input logic [3:0] rd, rs, rt,
                       input logic rsu, rtu, mr, mw, fr, fl);
    case (d)
      DA: {a_if.id_rd, a_if.id_rs, a_if.id_rt, a_if.id_rs_used, a_if.id_rt_used,
           a_if.id_mem_read, a_if.id_mem_write, a_if.freeze, a_if.flush} =
          {rd, rs, rt, rsu, rtu, mr, mw, fr, fl};
      DB: {b_if.id_rd, b_if.id_rs, b_if.id_rt, b_if.id_rs_used, b_if.id_rt_used,
           b_if.id_mem_read, b_if.id_mem_write, b_if.freeze, b_if.flush} =
          {rd, rs, rt, rsu, rtu, mr, mw, fr, fl};
      DC: {c_if.id_rd, c_if.id_rs, c_if.id_rt, c_if.id_rs_used, c_if.id_rt_used,
           c_if.id_mem_read, c_if.id_mem_write, c_if.freeze, c_if.flush} =
          {rd, rs, rt, rsu, rtu, mr, mw, fr, fl};
      default: {d_if.id_rd, d_if.id_rs, d_if.id_rt, d_if.id_rs_used, d_if.id_rt_used,
                d_if.id_mem_read, d_if.id_mem_write, d_if.freeze, d_if.flush} =
               {rd, rs, rt, rsu, rtu, mr, mw, fr, fl};
    endcase
  endtask

  // All three stall outputs packed as {stall_pc, stall_if_id, set_ctrl_zero}.
  function automatic logic [31:0] obs_stall(input int d);
    logic [2:0] s;
    case (d)
      DA:      s = {a_if.stall_pc, a_if.stall_if_id, a_if.set_ctrl_zero};
      DB:      s = {b_if.stall_pc, b_if.stall_if_id, b_if.set_ctrl_zero};
      DC:      s = {c_if.stall_pc, c_if.stall_if_id, c_if.set_ctrl_zero};
      default: s = {d_if.stall_pc, d_if.stall_if_id, d_if.set_ctrl_zero};
    endcase
    return 32'(s);
  endfunction

  function automatic logic [31:0] obs_cnt(input int d);
    case (d)
      DA:      return 32'(a_if.stall_cnt);
      DB:      return 32'(b_if.stall_cnt);
      DC:      return 32'(c_if.stall_cnt);
      default: return 32'(d_if.stall_cnt);
    endcase
  endfunction

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL sb_empty: observed %0d expected a queued value", obs);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  // One IF/ID cycle: drive after the edge, queue the expected stall, sample.
  task automatic step(input int d, input string tag, input logic [3:0] rd, rs, rt,
                      input logic rsu, rtu, mr, mw, fr, fl, input logic exp_stall);
    @(posedge clk);
    #1;
    drive(d, rd, rs, rt, rsu, rtu, mr, mw, fr, fl);
    push_exp(tag, exp_stall ? 32'd7 : 32'd0);
    #2;
    compare(obs_stall(d));
  endtask

  task automatic ld(input int d, input string tag, input logic [3:0] rd, input logic exp_stall);
    step(d, tag, rd, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_stall);
  endtask

  task automatic use_rs(input int d, input string tag, input logic [3:0] rs, input logic exp_stall);
    step(d, tag, 4'd1, rs, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_stall);
  endtask

  task automatic idle(input int d, input string tag);
    step(d, tag, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_cnt(input int d, input string tag, input logic [31:0] exp_v);
    push_exp(tag, exp_v);
    compare(obs_cnt(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) drive(d, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    push_exp("rst_stall_a", 32'd0); compare(obs_stall(DA));
    chk_cnt(DA, "rst_cnt_a", 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ---------------- A: default parameters ----------------
    ld    (DA, "a_ld_r3", 4'd3, 1'b0);
    use_rs(DA, "a_use_r3_stall", 4'd3, 1'b1);
    use_rs(DA, "a_use_r3_adv", 4'd3, 1'b0);
    chk_cnt(DA, "a_cnt_r3", 1);

    // Load whose rd equals its own rs: only an older entry stalls it.
    step(DA, "a_self_first", 4'd4, 4'd4, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(DA, "a_self_older", 4'd4, 4'd4, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(DA, "a_self_issue", 4'd4, 4'd4, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle  (DA, "a_idle1");
    chk_cnt(DA, "a_cnt_self", 2);

    // Back-to-back load to the same rd reloads the countdown.
    ld    (DA, "a_ld_r6", 4'd6, 1'b0);
    ld    (DA, "a_ld_r6_again", 4'd6, 1'b0);
    use_rs(DA, "a_use_r6_reload", 4'd6, 1'b1);
    idle  (DA, "a_idle2");

    // Mem-to-mem exemption: store data pending is fine, store address is not.
    ld  (DA, "a_ld_r5", 4'd5, 1'b0);
    step(DA, "a_st_rt5_mm", 4'd0, 4'd2, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ld  (DA, "a_ld_r5_b", 4'd5, 1'b0);
    step(DA, "a_st_rs5_stall", 4'd0, 4'd5, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(DA, "a_st_rs5_adv", 4'd0, 4'd5, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Zero register never tracked; unused rt never hits.
    ld    (DA, "a_ld_r0", 4'd0, 1'b0);
    use_rs(DA, "a_use_r0", 4'd0, 1'b0);
    ld    (DA, "a_ld_r8", 4'd8, 1'b0);
    step  (DA, "a_rt8_unused", 4'd1, 4'd1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Flush coinciding with a pending hazard wins.
    ld    (DA, "a_ld_r7", 4'd7, 1'b0);
    step  (DA, "a_flush_r7", 4'd1, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    use_rs(DA, "a_use_r7_after_flush", 4'd7, 1'b0);
    chk_cnt(DA, "a_cnt_mid", 4);

    // Freeze masks the stall and holds the countdown.
    ld    (DA, "a_ld_r9", 4'd9, 1'b0);
    step  (DA, "a_freeze_r9", 4'd1, 4'd9, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    use_rs(DA, "a_use_r9_stall", 4'd9, 1'b1);
    use_rs(DA, "a_use_r9_adv", 4'd9, 1'b0);
    chk_cnt(DA, "a_cnt_freeze", 5);
    drive(DA, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---------------- B: LOAD_USE_CYCLES = 2 ----------------
    ld    (DB, "b_ld_r3", 4'd3, 1'b0);
    use_rs(DB, "b_use_r3_s1", 4'd3, 1'b1);
    use_rs(DB, "b_use_r3_s2", 4'd3, 1'b1);
    use_rs(DB, "b_use_r3_adv", 4'd3, 1'b0);
    chk_cnt(DB, "b_cnt_2", 2);

    ld    (DB, "b_ld_r3_f", 4'd3, 1'b0);
    use_rs(DB, "b_hold1", 4'd3, 1'b1);
    for (int i = 0; i < 3; i++)
      step(DB, "b_hold_frz", 4'd1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    use_rs(DB, "b_hold5", 4'd3, 1'b1);
    use_rs(DB, "b_frz_adv", 4'd3, 1'b0);
    chk_cnt(DB, "b_cnt_frz", 4);

    // Flush squashes the young load even though it had cycles left.
    ld    (DB, "b_ld_r7", 4'd7, 1'b0);
    step  (DB, "b_flush", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    use_rs(DB, "b_use_r7_squashed", 4'd7, 1'b0);
    chk_cnt(DB, "b_cnt_flush", 4);
    drive(DB, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---------------- C: MM_FWD_EN = 0 ----------------
    ld  (DC, "c_ld_r5", 4'd5, 1'b0);
    step(DC, "c_st_rt5_stall", 4'd0, 4'd2, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(DC, "c_st_rt5_adv", 4'd0, 4'd2, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ld  (DC, "c_ld_r5_b", 4'd5, 1'b0);
    step(DC, "c_st_rs5_stall", 4'd0, 4'd5, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(DC, "c_st_rs5_adv", 4'd0, 4'd5, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt(DC, "c_cnt", 2);
    drive(DC, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---------------- D: PERF_W = 2, saturation ----------------
    for (int i = 0; i < 5; i++) begin
      ld    (DD, "d_ld_r1", 4'd1, 1'b0);
      use_rs(DD, "d_use_r1", 4'd1, 1'b1);
      idle  (DD, "d_idle");
      chk_cnt(DD, "d_cnt_sat", (i + 1 > 3) ? 32'd3 : 32'(i + 1));
    end

    // ---------------- Asynchronous reset mid-stall ----------------
    ld    (DA, "a_ld_r10", 4'd10, 1'b0);
    use_rs(DA, "a_use_r10_stall", 4'd10, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    push_exp("a_rst_mid_stall", 32'd0); compare(obs_stall(DA));
    chk_cnt(DA, "a_rst_mid_cnt", 0);
    chk_cnt(DD, "d_rst_mid_cnt", 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    use_rs(DA, "a_use_r10_after_rst", 4'd10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
